// File: rtl/forward_pass_mac_pkg.sv
// Shared types and arithmetic for the forward_pass MAC accumulator: FSM states,
// default widths and a width-generic saturating add/subtract.
package forward_pass_mac_pkg;

    localparam int PROD_WIDTH_DEF = 22;
    localparam int BIAS_WIDTH_DEF = 16;
    localparam int ACC_WIDTH_DEF  = 32;
    localparam int OUT_WIDTH_DEF  = 11;
    localparam int SHIFT_DEF      = 10;

    // Internal arithmetic width; wide enough that acc +/- product never wraps.
    localparam int WIDE = 64;

    localparam logic signed [ACC_WIDTH_DEF-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
    localparam logic signed [ACC_WIDTH_DEF-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_POST   = 2'd2,
        ST_OUTPUT = 2'd3
    } state_e;

    typedef struct packed {
        logic signed [WIDE-1:0] sum;
        logic                   sat;
    } sat_res_t;

    // base +/- mag, clamped to the signed range of 'width' bits.
    function automatic sat_res_t sat_addsub(input logic signed [WIDE-1:0] base,
                                            input logic        [WIDE-1:0] mag,
                                            input logic                   neg,
                                            input int unsigned            width);
        logic signed [WIDE-1:0] lim_max;
        logic signed [WIDE-1:0] lim_min;
        logic signed [WIDE-1:0] raw;
        sat_res_t               res;
        lim_max = (64'sd1 <<< (width - 1)) - 64'sd1;
        lim_min = -(64'sd1 <<< (width - 1));
        raw     = neg ? (base - signed'(mag)) : (base + signed'(mag));
        res.sum = raw;
        res.sat = 1'b0;
        if (raw > lim_max) begin
            res.sum = lim_max;
            res.sat = 1'b1;
        end else if (raw < lim_min) begin
            res.sum = lim_min;
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/forward_pass_mac_post.sv
// Combinational post-processing of the accumulator: arithmetic rescale,
// ReLU and high-side clip to the unsigned activation width.
module forward_pass_mac_post
    import forward_pass_mac_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int SHIFT     = SHIFT_DEF
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    output logic        [OUT_WIDTH-1:0] data_o,
    output logic                        clip_o
);

    logic signed [ACC_WIDTH-1:0] scaled;

    assign scaled = acc_i >>> SHIFT;

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        data_o = '0;
        clip_o = 1'b0;
        if (scaled[ACC_WIDTH-1]) begin
            data_o = '0;
        end else if (|scaled[ACC_WIDTH-2:OUT_WIDTH]) begin
            data_o = '1;
            clip_o = 1'b1;
        end else begin
            data_o = scaled[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/forward_pass_mac_acc.sv
// Neuron accumulator: sums signed-tagged products onto a bias, then rescales,
// applies ReLU/saturation and hands one activation per neuron downstream.
module forward_pass_mac_acc
    import forward_pass_mac_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int BIAS_WIDTH = BIAS_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int SHIFT      = SHIFT_DEF
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROD_WIDTH-1:0] in_prod,
    input  logic                  in_neg,
    input  logic [BIAS_WIDTH-1:0] in_bias,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic [15:0]           beat_cnt
);

    state_e                      state_q,     state_d;
    logic signed [ACC_WIDTH-1:0] acc_q,       acc_d;
    logic                        acc_sat_q,   acc_sat_d;
    logic [15:0]                 beat_cnt_q,  beat_cnt_d;
    logic                        out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]        out_data_q,  out_data_d;
    logic                        out_sat_q,   out_sat_d;

    logic                        beat_fire;
    logic signed [WIDE-1:0]      base_wide;
    logic [WIDE-1:0]             mag_wide;
    sat_res_t                    sum_res;
    logic [OUT_WIDTH-1:0]        post_data;
    logic                        post_clip;

    // Gated by reset so upstream never sees a ready while the block is held.
    assign in_ready  = ap_rst_n & ((state_q == ST_IDLE) | (state_q == ST_ACCUM));
    assign beat_fire = in_valid & in_ready;

    // The first beat of a neuron seeds from the bias instead of the running sum.
    assign base_wide = (state_q == ST_IDLE)
                     ? {{(WIDE-BIAS_WIDTH){in_bias[BIAS_WIDTH-1]}}, in_bias}
                     : {{(WIDE-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q};
    assign mag_wide  = {{(WIDE-PROD_WIDTH){1'b0}}, in_prod};
    assign sum_res   = sat_addsub(base_wide, mag_wide, in_neg, ACC_WIDTH);

    forward_pass_mac_post #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_post (
        .acc_i  (acc_q),
        .data_o (post_data),
        .clip_o (post_clip)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_sat_d   = acc_sat_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (beat_fire) begin
                    acc_d      = sum_res.sum[ACC_WIDTH-1:0];
                    acc_sat_d  = sum_res.sat;
                    beat_cnt_d = 16'd1;
                    state_d    = in_last ? ST_POST : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat_fire) begin
                    acc_d      = sum_res.sum[ACC_WIDTH-1:0];
                    acc_sat_d  = acc_sat_q | sum_res.sat;
                    beat_cnt_d = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;
                    if (in_last) state_d = ST_POST;
                end
            end
            ST_POST: begin
                out_data_d  = post_data;
                out_sat_d   = post_clip | acc_sat_q;
                out_valid_d = 1'b1;
                state_d     = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_sat_d   = 1'b0;
                    beat_cnt_d  = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            acc_sat_q   <= 1'b0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_sat_q   <= acc_sat_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign beat_cnt  = beat_cnt_q;

endmodule
